// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command/response to APB4 requester.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states.
module apb_master_bridge #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PResetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PSELx,
    output logic                    PWRITE,
    output logic                    PENABLE,
    output logic [DATA_WIDTH/8-1:0] PWSTRB,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    if (DATA_WIDTH % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb_master_bridge: bad DATA_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;
    logic   accept, done, timeout;

    always_ff @(posedge PCLK or negedge PResetn) begin
        if (!PResetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        accept    = state == IDLE && cmd_valid;
        done      = state == ACCESS && (PREADY || timeout);
        state_nxt = accept ? SETUP : state == SETUP ? ACCESS : done ? IDLE : state;
    end

    // Bus-phase outputs decode the state flops so reset drops them at once
    assign cmd_ready = state == IDLE;
    assign PSELx     = state != IDLE;
    assign PENABLE   = state == ACCESS;

    always_ff @(posedge PCLK or negedge PResetn) begin
        if (!PResetn) begin
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PWSTRB    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= done;
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PWSTRB <= cmd_write ? cmd_strb : '0;
            end
            if (done) begin
                rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                rsp_err   <= PREADY ? PSLVERR : 1'b1;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge PCLK or negedge PResetn) begin
        if (!PResetn)                          wait_cnt <= '0;
        else if (state == SETUP)               wait_cnt <= '0;
        else if (state == ACCESS && !PREADY)   wait_cnt <= wait_cnt + 1'b1;
    end

    // Abort on the edge where the count reaches TIMEOUT_CYCLES; PREADY on that edge wins
    assign timeout = state == ACCESS && !PREADY && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed vector table plus multi-cycle corner sequences.
module tb_apb_master_bridge;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          PCLK = 1'b0;
    logic          PResetn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_write = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] PADDR;
    logic          PSELx, PWRITE, PENABLE;
    logic [3:0]    PWSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA = '0;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;

    apb_master_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PResetn(PResetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSELx(PSELx), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PWSTRB(PWSTRB), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    strb;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [3:0]    exp_strb;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge PCLK);
        chk($sformatf("v%0d_idle_ready", idx), cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        PREADY = 1'b0; PRDATA = 32'hDEADBEEF; PSLVERR = 1'b1;
        @(negedge PCLK);
        chk($sformatf("v%0d_setup_psel", idx), PSELx, 1);
        chk($sformatf("v%0d_setup_pen", idx), PENABLE, 0);
        chk($sformatf("v%0d_setup_ready", idx), cmd_ready, 0);
        chk($sformatf("v%0d_pwstrb", idx), PWSTRB, v.exp_strb);
        chk($sformatf("v%0d_pwrite", idx), PWRITE, v.wr);
        chk($sformatf("v%0d_pwdata", idx), PWDATA, v.wdata);
        chk($sformatf("v%0d_paddr", idx), PADDR, v.addr);
        cmd_valid = 1'b0; cmd_addr = '1; cmd_strb = 4'hF; cmd_write = ~v.wr;
        for (int k = 0; k <= v.waits; k++) begin
            @(negedge PCLK);
            chk($sformatf("v%0d_acc%0d_pen", idx, k), PENABLE, 1);
            chk($sformatf("v%0d_acc%0d_psel", idx, k), PSELx, 1);
            chk($sformatf("v%0d_acc%0d_paddr", idx, k), PADDR, v.addr);
            chk($sformatf("v%0d_acc%0d_pwstrb", idx, k), PWSTRB, v.exp_strb);
            chk($sformatf("v%0d_acc%0d_rsp", idx, k), rsp_valid, 0);
            PREADY  = k == v.waits;
            PRDATA  = (k == v.waits) ? v.prdata : 32'hDEADBEEF;
            PSLVERR = (k == v.waits) ? v.slverr : 1'b1;
        end
        @(negedge PCLK);
        PREADY = 1'b0; PSLVERR = 1'b0;
        chk($sformatf("v%0d_rsp_valid", idx), rsp_valid, 1);
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_err", idx), rsp_err, v.exp_err);
        chk($sformatf("v%0d_rsp_psel", idx), PSELx, 0);
        chk($sformatf("v%0d_rsp_ready", idx), cmd_ready, 1);
        @(negedge PCLK);
        chk($sformatf("v%0d_pulse_end", idx), rsp_valid, 0);
        chk($sformatf("v%0d_rdata_hold", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_paddr_hold", idx), PADDR, v.addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        logic       b2b_psel[6];
        logic       b2b_pen[6];
        logic       b2b_rsp[6];
        logic [7:0] b2b_addr[6];
        vecs[0] = '{1'b1, 32'h4,  32'h000000A5, 4'b0001, 0,  32'h0,        1'b0, 32'h0,        1'b0, 4'b0001};
        vecs[1] = '{1'b0, 32'h8,  32'h0,        4'b1111, 3,  32'h12345678, 1'b0, 32'h12345678, 1'b0, 4'b0000};
        vecs[2] = '{1'b0, 32'h14, 32'h0,        4'b0000, 1,  32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 1'b1, 4'b0000};
        vecs[3] = '{1'b1, 32'h18, 32'h11223344, 4'b1111, 0,  32'h99999999, 1'b0, 32'h0,        1'b0, 4'b1111};
        vecs[4] = '{1'b1, 32'h1C, 32'hA0B0C0D0, 4'b0110, 2,  32'h13579BDF, 1'b1, 32'h0,        1'b1, 4'b0110};
        vecs[5] = '{1'b0, 32'h28, 32'h0,        4'b0000, 15, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 4'b0000};

        #2;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_psel", PSELx, 0);
        chk("rst_pen", PENABLE, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwstrb", PWSTRB, 0);
        @(negedge PCLK);
        @(negedge PCLK);
        PResetn = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // back-to-back: write 0xC then read 0x10 with cmd_valid held
        b2b_psel = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        b2b_pen  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        b2b_rsp  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        b2b_addr = '{8'h0C, 8'h0C, 8'h0C, 8'h10, 8'h10, 8'h10};
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'hC;
        cmd_wdata = 32'h0C0C0C0C; cmd_strb = 4'hF;
        PREADY = 1'b1; PRDATA = 32'h55AA55AA; PSLVERR = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            chk($sformatf("b2b%0d_psel", i), PSELx, b2b_psel[i]);
            chk($sformatf("b2b%0d_pen", i), PENABLE, b2b_pen[i]);
            chk($sformatf("b2b%0d_rsp", i), rsp_valid, b2b_rsp[i]);
            chk($sformatf("b2b%0d_ready", i), cmd_ready, b2b_rsp[i]);
            chk($sformatf("b2b%0d_paddr", i), PADDR, {24'h0, b2b_addr[i]});
            if (i == 0) begin cmd_write = 1'b0; cmd_addr = 32'h10; end
            if (i == 2) chk("b2b_wr_rdata", rsp_rdata, 0);
            if (i == 3) cmd_valid = 1'b0;
            if (i == 5) chk("b2b_rd_rdata", rsp_rdata, 32'h55AA55AA);
        end
        PREADY = 1'b0;

        // reset during a wait state
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_rst_pen_before", PENABLE, 1);
        #2 PResetn = 1'b0;
        #1;
        chk("mid_rst_psel", PSELx, 0);
        chk("mid_rst_pen", PENABLE, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        PREADY = 1'b1; PRDATA = 32'h44444444;
        @(negedge PCLK);
        @(negedge PCLK);
        PResetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            chk($sformatf("post_rst%0d_rsp", i), rsp_valid, 0);
            chk($sformatf("post_rst%0d_psel", i), PSELx, 0);
            chk($sformatf("post_rst%0d_ready", i), cmd_ready, 1);
        end
        PREADY = 1'b0;

        // PREADY held low forever
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h24;
        PRDATA = 32'h77777777; PSLVERR = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
`ifdef APB_TIMEOUT_EN
        begin
            int  n = 0;
            bit  seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge PCLK);
                if (rsp_valid) seen = 1'b1;
                else if (PENABLE) n++;
            end
            chk("to_seen", seen, 1);
            chk("to_access_cycles", n, TO);
            chk("to_err", rsp_err, 1);
            chk("to_rdata", rsp_rdata, 0);
            chk("to_psel", PSELx, 0);
            chk("to_ready", cmd_ready, 1);
        end
`else
        begin
            int stray = 0;
            repeat (100) begin
                @(negedge PCLK);
                if (rsp_valid) stray++;
            end
            chk("nt_no_rsp", stray, 0);
            chk("nt_pen", PENABLE, 1);
            chk("nt_paddr", PADDR, 32'h24);
            PREADY = 1'b1;
            @(negedge PCLK);
            PREADY = 1'b0;
            chk("nt_done", rsp_valid, 1);
            chk("nt_rdata", rsp_rdata, 32'h77777777);
            chk("nt_err", rsp_err, 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB4 requester: turns a simple single-outstanding command/response interface into APB SETUP/ACCESS transfers.
- Drives the UART peripheral's APB slave port: control/status reads, TX FIFO writes, RX FIFO reads from an on-chip controller or test sequencer.
- One transfer in flight at a time. Response is a registered one-cycle pulse.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA/command data width; multiple of 8.
- ADDR_WIDTH, 32, PADDR/command address width.
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  single clock.
- PResetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  byte strobes (writes only).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  PSLVERR or timeout seen.
- PADDR  out  ADDR_WIDTH  APB address.
- PSELx  out  1  peripheral select.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  ACCESS phase.
- PWSTRB  out  DATA_WIDTH/8  APB write strobes.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  APB read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PResetn=0): state IDLE. All outputs 0 except cmd_ready=1. Any transfer in progress is dropped immediately: PSELx and PENABLE fall asynchronously and no rsp_valid is issued.
- States:
  - IDLE -> SETUP on command accept.
  - SETUP -> ACCESS unconditionally.
  - ACCESS -> IDLE when PREADY=1, or on timeout.
  - ACCESS -> ACCESS otherwise.
- cmd_ready = 1 only in IDLE (registered). Commands are never accepted in SETUP or ACCESS.
- Accept edge: register cmd_addr->PADDR, cmd_write->PWRITE, cmd_wdata->PWDATA. PWSTRB = cmd_strb for writes, forced to 0 for reads (APB4 rule).
- SETUP: PSELx=1, PENABLE=0.
- ACCESS: PSELx=1, PENABLE=1.
- PADDR, PWRITE, PWDATA and PWSTRB stay stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE.
- Completion edge (ACCESS with PREADY=1):
  - Next cycle: PSELx=0, PENABLE=0, state IDLE, rsp_valid=1 for exactly one cycle.
  - rsp_rdata = PRDATA sampled on this edge for reads, 0 for writes.
  - rsp_err = PSLVERR sampled on this edge.
- rsp_rdata and rsp_err hold until the next completion. PRDATA and PSLVERR are ignored at all other times.
- Latency with zero wait states:
  - accept edge T;
  - SETUP in T+1;
  - ACCESS in T+2;
  - rsp_valid in T+3, coincident with cmd_ready=1.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- Back-to-back: if cmd_valid is held high, the next command is accepted in the rsp_valid cycle. Minimum 3 cycles per transfer, with one IDLE cycle between PSELx pulses.
- cmd_valid high while cmd_ready=0: no effect. The command is not captured; the requester must hold it.
- No response backpressure: the consumer must take rsp_valid when it pulses.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- With it defined:
  - A wait counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to ACCESS and increments on each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0: abort. Next cycle PSELx=PENABLE=0, state IDLE, rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - PREADY=1 on the same edge as the count is reached wins: normal completion.
- Without it: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Write, zero wait: cmd addr=0x4, wdata=0x000000A5, strb=4'b0001, PREADY=1.
  -> PSELx high in T+1..T+2, PENABLE high in T+2, PWSTRB=0001, rsp_valid in T+3 with rsp_err=0 and rsp_rdata=0.
- Read, 3 wait states: addr=0x8, PREADY low for 3 ACCESS cycles, then PRDATA=0x12345678.
  -> PWSTRB=0, PADDR stable throughout, rsp_valid at T+6 with rsp_rdata=0x12345678.
- Slave error: read with PSLVERR=1 on the PREADY edge.
  -> rsp_err=1; the following clean write returns rsp_err=0.
- Back-to-back: cmd_valid held for write 0xC then read 0x10.
  -> second accept in the first rsp_valid cycle; PSELx low for exactly one cycle between transfers.
- Reset mid-ACCESS: PResetn low during a wait state.
  -> PSELx and PENABLE fall before the next edge, no rsp_valid, cmd_ready=1 after release.
- APB_TIMEOUT_EN with TIMEOUT_CYCLES=16, PREADY held 0.
  -> rsp_valid with rsp_err=1 and rsp_rdata=0 after 16 ACCESS cycles. Without the macro, no response after 100 cycles.
